// File: rtl/imem_boot_ctrl.sv
// Instruction RAM boot loader and fetch front-end: fills the RAM from a UART
// byte stream (16-bit count, then little-endian words), then releases the CPU.
module imem_boot_ctrl #(
    parameter int ADDR_W  = 6,
    parameter int TIMEOUT = 1_000_000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              reload,
    input  logic [31:0]       fetch_addr,
    output logic [31:0]       fetch_rd,
    output logic              fetch_valid,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [31:0]       mem_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_reset_n,
    output logic              load_busy,
    output logic              load_err,
    output logic [15:0]       words_loaded
);

    localparam logic [16:0] DEPTH   = 17'(2 ** ADDR_W);
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT) - 32'd1;
    localparam bit          TO_EN   = (TIMEOUT != 0);

    typedef enum logic [2:0] {LEN0, LEN1, DATA, DONE, RUN} state_t;

    state_t              state_q, state_d;
    logic [15:0]         n_q, n_d;
    logic [15:0]         widx_q, widx_d;
    logic [1:0]          lane_q, lane_d;
    logic [23:0]         asm_q, asm_d;
    logic [31:0]         idle_q, idle_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                err_q, err_d;
    logic [15:0]         words_q, words_d;
    logic                cpu_rst_n_q, cpu_rst_n_d;
    logic [ADDR_W-1:0]   praddr_q;
    logic                prun_q;
    logic [31:0]         word;
    logic                timeout_hit;

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        widx_d      = widx_q;
        lane_d      = lane_q;
        asm_d       = asm_q;
        we_d        = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        err_d       = err_q;
        words_d     = words_q;
        word        = {rx_data, asm_q};
        timeout_hit = TO_EN && !rx_valid && (idle_q == TO_LAST);

        // Idle time only matters once a load has started (LEN1/DATA).
        if (rx_valid || !(state_q == LEN1 || state_q == DATA))
            idle_d = '0;
        else
            idle_d = idle_q + 32'd1;

        case (state_q)
            LEN0: begin
                if (!reload && rx_valid) begin
                    n_d     = {n_q[15:8], rx_data};
                    err_d   = 1'b0;
                    state_d = LEN1;
                end
            end
            LEN1: begin
                if (reload) begin
                    state_d = LEN0;
                end else if (rx_valid) begin
                    n_d     = {rx_data, n_q[7:0]};
                    words_d = '0;
                    widx_d  = '0;
                    lane_d  = '0;
                    state_d = ({rx_data, n_q[7:0]} == 16'd0) ? DONE : DATA;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = LEN0;
                end
            end
            DATA: begin
                if (reload) begin
                    state_d = LEN0;
                end else if (rx_valid) begin
                    lane_d = lane_q + 2'd1;
                    case (lane_q)
                        2'd0:    asm_d[7:0]   = rx_data;
                        2'd1:    asm_d[15:8]  = rx_data;
                        2'd2:    asm_d[23:16] = rx_data;
                        default: begin
                            // Words beyond the RAM are swallowed so the stream stays in sync.
                            if ({1'b0, widx_q} < DEPTH) begin
                                we_d    = 1'b1;
                                waddr_d = widx_q[ADDR_W-1:0];
                                wdata_d = word;
                                words_d = words_q + 16'd1;
                            end else begin
                                err_d = 1'b1;
                            end
                            widx_d = widx_q + 16'd1;
                            if (widx_q == n_q - 16'd1)
                                state_d = DONE;
                        end
                    endcase
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = LEN0;
                end
            end
            DONE: begin
                state_d = reload ? LEN0 : RUN;
            end
            RUN: begin
                if (reload) begin
                    state_d = LEN0;
                    words_d = '0;
                end
            end
            default: state_d = LEN0;
        endcase

        // CPU leaves reset one cycle after RUN is entered and drops with reload.
        cpu_rst_n_d = (state_q == RUN) && !reload;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= LEN0;
            n_q         <= '0;
            widx_q      <= '0;
            lane_q      <= '0;
            asm_q       <= '0;
            idle_q      <= '0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
            words_q     <= '0;
            cpu_rst_n_q <= 1'b0;
            praddr_q    <= '0;
            prun_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            widx_q      <= widx_d;
            lane_q      <= lane_d;
            asm_q       <= asm_d;
            idle_q      <= idle_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
            words_q     <= words_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            praddr_q    <= mem_raddr;
            prun_q      <= (state_q == RUN);
        end
    end

    logic unused_fetch_bits;
    assign unused_fetch_bits = ^{fetch_addr[31:ADDR_W+2], fetch_addr[1:0]};

    assign mem_raddr    = fetch_addr[ADDR_W+1:2];
    assign fetch_rd     = mem_rdata;
    assign fetch_valid  = (state_q == RUN) && prun_q && (praddr_q == mem_raddr);
    assign mem_we       = we_q;
    assign mem_waddr    = waddr_q;
    assign mem_wdata    = wdata_q;
    assign cpu_reset_n  = cpu_rst_n_q;
    assign load_busy    = (state_q != RUN);
    assign load_err     = err_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Directed bench for imem_boot_ctrl: a 64-word/TIMEOUT=8 instance and a
// 4-word/no-timeout instance, each backed by a small synchronous RAM model.
module tb_imem_boot_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, rx_valid, reload;
    logic [7:0]  rx_data;
    logic [31:0] fetch_addr, fetch_rd, mem_rdata, mem_wdata;
    logic        fetch_valid, mem_we, cpu_reset_n, load_busy, load_err;
    logic [5:0]  mem_raddr, mem_waddr;
    logic [15:0] words_loaded;

    logic        rx_valid2, reload2;
    logic [7:0]  rx_data2;
    logic [31:0] fetch_addr2, fetch_rd2, mem_rdata2, mem_wdata2;
    logic        fetch_valid2, mem_we2, cpu_reset_n2, load_busy2, load_err2;
    logic [1:0]  mem_raddr2, mem_waddr2;
    logic [15:0] words_loaded2;

    int n_cmp = 0;
    int n_err = 0;
    int we_cnt = 0;
    int we_cnt2 = 0;

    imem_boot_ctrl #(.ADDR_W(6), .TIMEOUT(8)) dut (
        .clk(clk), .reset_n(reset_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .reload(reload), .fetch_addr(fetch_addr), .fetch_rd(fetch_rd),
        .fetch_valid(fetch_valid), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .cpu_reset_n(cpu_reset_n), .load_busy(load_busy), .load_err(load_err),
        .words_loaded(words_loaded)
    );

    imem_boot_ctrl #(.ADDR_W(2), .TIMEOUT(0)) dut2 (
        .clk(clk), .reset_n(reset_n), .rx_valid(rx_valid2), .rx_data(rx_data2),
        .reload(reload2), .fetch_addr(fetch_addr2), .fetch_rd(fetch_rd2),
        .fetch_valid(fetch_valid2), .mem_raddr(mem_raddr2), .mem_rdata(mem_rdata2),
        .mem_we(mem_we2), .mem_waddr(mem_waddr2), .mem_wdata(mem_wdata2),
        .cpu_reset_n(cpu_reset_n2), .load_busy(load_busy2), .load_err(load_err2),
        .words_loaded(words_loaded2)
    );

    logic [31:0] ram1 [0:63];
    logic [31:0] ram2 [0:3];

    always @(posedge clk) begin
        if (mem_we) begin
            ram1[mem_waddr] <= mem_wdata;
            we_cnt <= we_cnt + 1;
        end
        mem_rdata <= ram1[mem_raddr];
        if (mem_we2) begin
            ram2[mem_waddr2] <= mem_wdata2;
            we_cnt2 <= we_cnt2 + 1;
        end
        mem_rdata2 <= ram2[mem_raddr2];
    end

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_byte2(input logic [7:0] b);
        rx_valid2 = 1'b1;
        rx_data2  = b;
        @(negedge clk);
        rx_valid2 = 1'b0;
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; rx_valid = 0; rx_data = 0; reload = 0; fetch_addr = 0;
        rx_valid2 = 0; rx_data2 = 0; reload2 = 0; fetch_addr2 = 0;
        repeat (2) @(negedge clk);
        n_cmp++; if (cpu_reset_n !== 1'b0) begin n_err++; $display("FAIL rst_cpu_reset_n: got %b want 0", cpu_reset_n); end
        n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
        n_cmp++; if (mem_waddr !== 6'd0) begin n_err++; $display("FAIL rst_mem_waddr: got %h want 0", mem_waddr); end
        n_cmp++; if (mem_wdata !== 32'd0) begin n_err++; $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata); end
        n_cmp++; if (load_err !== 1'b0) begin n_err++; $display("FAIL rst_load_err: got %b want 0", load_err); end
        n_cmp++; if (words_loaded !== 16'd0) begin n_err++; $display("FAIL rst_words: got %0d want 0", words_loaded); end
        n_cmp++; if (fetch_valid !== 1'b0) begin n_err++; $display("FAIL rst_fetch_valid: got %b want 0", fetch_valid); end
        n_cmp++; if (load_busy !== 1'b1) begin n_err++; $display("FAIL rst_load_busy: got %b want 1", load_busy); end
        n_cmp++; if (cpu_reset_n2 !== 1'b0) begin n_err++; $display("FAIL rst_cpu_reset_n2: got %b want 0", cpu_reset_n2); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_overflow();
        int base;
        logic [31:0] exp;
        base = we_cnt2;
        send_byte2(8'h05);
        send_byte2(8'h00);
        for (int j = 0; j < 5; j++) begin
            for (int l = 0; l < 4; l++) send_byte2(8'(16 * j + l));
            exp = {8'(16 * j + 3), 8'(16 * j + 2), 8'(16 * j + 1), 8'(16 * j)};
            if (j < 4) begin
                n_cmp++; if (mem_we2 !== 1'b1 || mem_waddr2 !== 2'(j) || mem_wdata2 !== exp) begin
                    n_err++; $display("FAIL ovf_write%0d: got we=%b a=%0d d=%h want we=1 a=%0d d=%h", j, mem_we2, mem_waddr2, mem_wdata2, j, exp);
                end
            end else begin
                n_cmp++; if (mem_we2 !== 1'b0) begin n_err++; $display("FAIL ovf_no_write: got we=%b want 0", mem_we2); end
            end
        end
        n_cmp++; if (load_err2 !== 1'b1) begin n_err++; $display("FAIL ovf_load_err: got %b want 1", load_err2); end
        n_cmp++; if (words_loaded2 !== 16'd4) begin n_err++; $display("FAIL ovf_words: got %0d want 4", words_loaded2); end
        repeat (2) @(negedge clk);
        n_cmp++; if (cpu_reset_n2 !== 1'b1) begin n_err++; $display("FAIL ovf_run: got cpu_reset_n=%b want 1", cpu_reset_n2); end
        n_cmp++; if (we_cnt2 - base !== 4) begin n_err++; $display("FAIL ovf_we_count: got %0d want 4", we_cnt2 - base); end
    endtask

    task automatic test_load3();
        logic [7:0]  b [12] = '{8'h0F, 8'h00, 8'h4F, 8'hE0, 8'h0F, 8'h10, 8'h4F, 8'hE0,
                                8'h01, 8'h30, 8'h83, 8'hE2};
        logic [31:0] w [3]  = '{32'hE04F000F, 32'hE04F100F, 32'hE2833001};
        int base;
        base = we_cnt;
        send_byte(8'h03);
        send_byte(8'h00);
        for (int i = 0; i < 12; i++) begin
            send_byte(b[i]);
            if (i % 4 == 3) begin
                n_cmp++; if (mem_we !== 1'b1 || mem_waddr !== 6'(i / 4) || mem_wdata !== w[i / 4]) begin
                    n_err++; $display("FAIL load3_write%0d: got we=%b a=%0d d=%h want we=1 a=%0d d=%h", i / 4, mem_we, mem_waddr, mem_wdata, i / 4, w[i / 4]);
                end
            end
        end
        n_cmp++; if (cpu_reset_n !== 1'b0) begin n_err++; $display("FAIL load3_cpu_k: got %b want 0", cpu_reset_n); end
        @(negedge clk);
        n_cmp++; if (cpu_reset_n !== 1'b0 || mem_we !== 1'b0) begin n_err++; $display("FAIL load3_k1: got cpu=%b we=%b want cpu=0 we=0", cpu_reset_n, mem_we); end
        @(negedge clk);
        n_cmp++; if (cpu_reset_n !== 1'b1) begin n_err++; $display("FAIL load3_cpu_k2: got %b want 1", cpu_reset_n); end
        n_cmp++; if (load_busy !== 1'b0) begin n_err++; $display("FAIL load3_busy: got %b want 0", load_busy); end
        n_cmp++; if (words_loaded !== 16'd3) begin n_err++; $display("FAIL load3_words: got %0d want 3", words_loaded); end
        n_cmp++; if (load_err !== 1'b0) begin n_err++; $display("FAIL load3_err: got %b want 0", load_err); end
        n_cmp++; if (we_cnt - base !== 3) begin n_err++; $display("FAIL load3_we_count: got %0d want 3", we_cnt - base); end
    endtask

    task automatic test_reload_rx();
        reload = 1'b1; rx_valid = 1'b1; rx_data = 8'h55;
        @(negedge clk);
        reload = 1'b0; rx_valid = 1'b0;
        n_cmp++; if (cpu_reset_n !== 1'b0) begin n_err++; $display("FAIL reload_cpu: got %b want 0", cpu_reset_n); end
        n_cmp++; if (words_loaded !== 16'd0) begin n_err++; $display("FAIL reload_words: got %0d want 0", words_loaded); end
        n_cmp++; if (load_busy !== 1'b1) begin n_err++; $display("FAIL reload_busy: got %b want 1", load_busy); end
    endtask

    task automatic test_len_zero();
        int base;
        base = we_cnt;
        send_byte(8'h00);
        send_byte(8'h00);
        @(negedge clk);
        n_cmp++; if (cpu_reset_n !== 1'b0) begin n_err++; $display("FAIL len0_cpu_k1: got %b want 0", cpu_reset_n); end
        @(negedge clk);
        n_cmp++; if (cpu_reset_n !== 1'b1) begin n_err++; $display("FAIL len0_cpu_k2: got %b want 1", cpu_reset_n); end
        n_cmp++; if (we_cnt - base !== 0) begin n_err++; $display("FAIL len0_no_write: got %0d writes want 0", we_cnt - base); end
        n_cmp++; if (words_loaded !== 16'd0) begin n_err++; $display("FAIL len0_words: got %0d want 0", words_loaded); end
    endtask

    task automatic test_fetch();
        fetch_addr = 32'h0;
        pulse_reload();
        send_byte(8'h00);
        send_byte(8'h00);
        @(negedge clk);
        #1;
        n_cmp++; if (fetch_valid !== 1'b0) begin n_err++; $display("FAIL fetch_first_run: got %b want 0", fetch_valid); end
        @(negedge clk); fetch_addr = 32'h4; #1;
        n_cmp++; if (fetch_valid !== 1'b0) begin n_err++; $display("FAIL fetch_change4: got %b want 0", fetch_valid); end
        @(negedge clk); #1;
        n_cmp++; if (fetch_valid !== 1'b1) begin n_err++; $display("FAIL fetch_hold4: got %b want 1", fetch_valid); end
        n_cmp++; if (fetch_rd !== 32'hE04F100F) begin n_err++; $display("FAIL fetch_rd4: got %h want e04f100f", fetch_rd); end
        @(negedge clk); fetch_addr = 32'h8; #1;
        n_cmp++; if (fetch_valid !== 1'b0) begin n_err++; $display("FAIL fetch_change8: got %b want 0", fetch_valid); end
        @(negedge clk); fetch_addr = 32'h103; #1;
        n_cmp++; if (mem_raddr !== 6'd0) begin n_err++; $display("FAIL fetch_wrap_addr: got %0d want 0", mem_raddr); end
        @(negedge clk); #1;
        n_cmp++; if (fetch_valid !== 1'b1 || fetch_rd !== 32'hE04F000F) begin
            n_err++; $display("FAIL fetch_wrap_rd: got v=%b d=%h want v=1 d=e04f000f", fetch_valid, fetch_rd);
        end
    endtask

    task automatic test_timeout();
        pulse_reload();
        send_byte(8'h03);
        send_byte(8'h00);
        for (int i = 1; i <= 6; i++) begin
            send_byte(8'(i));
            if (i == 4) begin
                n_cmp++; if (mem_we !== 1'b1 || mem_waddr !== 6'd0 || mem_wdata !== 32'h04030201) begin
                    n_err++; $display("FAIL to_write0: got we=%b a=%0d d=%h want we=1 a=0 d=04030201", mem_we, mem_waddr, mem_wdata);
                end
            end
        end
        repeat (7) @(negedge clk);
        n_cmp++; if (load_err !== 1'b0) begin n_err++; $display("FAIL to_early: got load_err=%b want 0 after 7 idle", load_err); end
        @(negedge clk);
        n_cmp++; if (load_err !== 1'b1) begin n_err++; $display("FAIL to_fire: got load_err=%b want 1 after 8 idle", load_err); end
        n_cmp++; if (cpu_reset_n !== 1'b0 || load_busy !== 1'b1) begin n_err++; $display("FAIL to_state: got cpu=%b busy=%b want 0 1", cpu_reset_n, load_busy); end
        send_byte(8'h01);
        n_cmp++; if (load_err !== 1'b0) begin n_err++; $display("FAIL to_err_clear: got %b want 0", load_err); end
        send_byte(8'h00);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        n_cmp++; if (mem_we !== 1'b1 || mem_waddr !== 6'd0 || mem_wdata !== 32'hDDCCBBAA) begin
            n_err++; $display("FAIL to_reload_write: got we=%b a=%0d d=%h want we=1 a=0 d=ddccbbaa", mem_we, mem_waddr, mem_wdata);
        end
        repeat (2) @(negedge clk);
        n_cmp++; if (cpu_reset_n !== 1'b1 || words_loaded !== 16'd1) begin
            n_err++; $display("FAIL to_reload_run: got cpu=%b words=%0d want 1 1", cpu_reset_n, words_loaded);
        end
    endtask

    task automatic test_reset_mid_word();
        int base;
        pulse_reload();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        rx_valid = 1'b1; rx_data = 8'hDD; reset_n = 1'b0;
        #1;
        base = we_cnt;
        n_cmp++; if (mem_we !== 1'b0 || mem_waddr !== 6'd0 || mem_wdata !== 32'd0) begin
            n_err++; $display("FAIL mid_rst_mem: got we=%b a=%0d d=%h want 0 0 0", mem_we, mem_waddr, mem_wdata);
        end
        n_cmp++; if (cpu_reset_n !== 1'b0 || load_busy !== 1'b1 || load_err !== 1'b0 || words_loaded !== 16'd0 || fetch_valid !== 1'b0) begin
            n_err++; $display("FAIL mid_rst_outs: got cpu=%b busy=%b err=%b words=%0d fv=%b want 0 1 0 0 0", cpu_reset_n, load_busy, load_err, words_loaded, fetch_valid);
        end
        @(negedge clk);
        rx_valid = 1'b0;
        n_cmp++; if (mem_we !== 1'b0 || we_cnt - base !== 0) begin n_err++; $display("FAIL mid_rst_nowrite: got we=%b writes=%0d want 0 0", mem_we, we_cnt - base); end
        reset_n = 1'b1;
        @(negedge clk);
        send_byte(8'h00); send_byte(8'h00);
        repeat (2) @(negedge clk);
        n_cmp++; if (cpu_reset_n !== 1'b1) begin n_err++; $display("FAIL mid_rst_relaunch: got cpu=%b want 1", cpu_reset_n); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_overflow();
        test_load3();
        test_reload_rx();
        test_len_zero();
        test_fetch();
        test_timeout();
        test_reset_mid_word();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/imem_boot_ctrl.md
# imem_boot_ctrl

Boot and access controller for the synchronous single-port instruction RAM. After reset it holds the CPU in reset and fills the RAM from a UART byte stream. The stream is a 16-bit word count followed by little-endian instruction words. It then releases the CPU and serves instruction fetches, flagging when read data matches the requested PC.

## Interface

- ADDR_W, 6: RAM word-address width; DEPTH = 2**ADDR_W words.
- TIMEOUT, 1_000_000: idle cycles allowed between bytes mid-load before abort; 0 disables the timeout.

- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- rx_valid  in  1  one-cycle strobe, rx_data holds a received byte
- rx_data  in  8  received byte
- reload  in  1  one-cycle pulse: restart load sequence
- fetch_addr  in  32  CPU PC, byte address
- fetch_rd  out  32  instruction word = mem_rdata
- fetch_valid  out  1  fetch_rd corresponds to current fetch_addr
- mem_raddr  out  ADDR_W  RAM read address (combinational)
- mem_rdata  in  32  RAM read data, 1-cycle latency
- mem_we  out  1  RAM write enable (registered)
- mem_waddr  out  ADDR_W  RAM write address (registered)
- mem_wdata  out  32  RAM write data (registered)
- cpu_reset_n  out  1  CPU reset, low while loading (registered)
- load_busy  out  1  high in any load state
- load_err  out  1  sticky error flag
- words_loaded  out  16  words written in the current or last load

## Operation

- States: LEN0, LEN1, DATA, DONE, RUN. Reset state is LEN0.
- Reset values: cpu_reset_n=0, mem_we=0, mem_waddr=0, mem_wdata=0, load_err=0, words_loaded=0, fetch_valid=0, load_busy=1.
- LEN0: a byte sets N[7:0] and clears load_err. Go to LEN1.
- LEN1: a byte sets N[15:8]. If N==0, go to DONE. Otherwise clear the word index and byte lane, then go to DATA.
- DATA: bytes fill lanes 0..3 of the assembly register, lane 0 into bits [7:0]. On lane 3:
  - If word index < DEPTH: issue one write next cycle and increment words_loaded.
  - If word index ≥ DEPTH: the word is consumed and discarded, and load_err is set.
  - Increment the word index. After word N-1, go to DONE.
- DONE: one cycle, then go to RUN.
- RUN: cpu_reset_n=1 and rx bytes are ignored. reload goes to LEN0, drives cpu_reset_n=0, and clears words_loaded.
- reload in LEN1, DATA or DONE aborts to LEN0 without setting load_err. RAM contents already written stay.
- Timeout: in LEN1 and DATA, an idle counter increments each cycle without rx_valid and clears on rx_valid. When it reaches TIMEOUT, set load_err and go to LEN0. cpu_reset_n stays 0.
- Simultaneous reload and rx_valid: reload wins and the byte is dropped.
- Simultaneous timeout and rx_valid: the byte wins and the counter clears.
- Fetch: mem_raddr = fetch_addr[ADDR_W+1:2]. Bits [1:0] are ignored; upper bits wrap modulo DEPTH. fetch_rd = mem_rdata at all times.
- fetch_valid = (state==RUN) && (registered previous mem_raddr == current mem_raddr) && (previous cycle was also RUN).
- mem_raddr tracks fetch_addr in every state. The RAM is written only through the mem_we path.
- load_busy = state ∈ {LEN0, LEN1, DATA, DONE}.

## Timing

- Byte accepted at edge k completing a word: mem_we=1 for exactly one cycle, k to k+1, with the address and data for that word.
- Last byte accepted at edge k: DONE during cycle k+1, RUN and cpu_reset_n=1 from edge k+2.
- N==0, second length byte at edge k: cpu_reset_n=1 from edge k+2.
- Consecutive rx_valid on every cycle is supported; there is no backpressure.
- Fetch after a PC change: fetch_valid=0 for one cycle, then 1 while the PC is held. The first cycle of RUN always has fetch_valid=0.
- Asynchronous reset mid-load: immediate return to LEN0 with reset values. No further writes occur.

## Test plan

- Load N=3 with bytes 0F 00 4F E0, 0F 10 4F E0, 01 30 83 E2 → writes E04F000F@0, E04F100F@1, E2833001@2; words_loaded=3; cpu_reset_n high 2 cycles after the last byte; load_err=0.
- N=0 → no mem_we; cpu_reset_n=1 two cycles after the second length byte.
- ADDR_W=2 with N=5 → writes only to addresses 0..3; 5th word consumed without mem_we; load_err=1; RUN entered.
- TIMEOUT=8, stop after 6 data bytes → load_err=1 after 8 idle cycles, state LEN0, cpu_reset_n=0; a subsequent clean load clears load_err.
- In RUN, fetch_addr 0→4→4→8 with RAM preloaded → fetch_valid pattern 0,0,1,0 (first RUN cycle 0). fetch_rd equals RAM[1] on the cycle fetch_valid=1. fetch_addr=0x103 with ADDR_W=6 reads word 0.
- reload in RUN together with rx_valid → byte dropped, cpu_reset_n=0 next cycle, words_loaded=0. Reset asserted mid-word → no mem_we and all outputs at reset values.
